// File: rtl/tmds_channel_sequencer.sv
// Feeds the three TMDS lane symbol FIFOs from one symbol-triple stream: primes them with filler,
// then writes aligned triples with a single shared strobe, padding with filler when upstream starves.
module tmds_channel_sequencer #(
    parameter logic [9:0] FILLER_CH0   = 10'b1101010100,
    parameter logic [9:0] FILLER_CH1   = 10'b1101010100,
    parameter logic [9:0] FILLER_CH2   = 10'b1101010100,
    parameter int         PRIME_WRITES = 8,
    parameter int         MISALIGN_LIM = 4,
    parameter int         CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             enable_i,
    input  logic             clear_stats_i,
    input  logic             sym_valid_i,
    output logic             sym_ready_o,
    input  logic [29:0]      sym_data_i,
    input  logic [2:0]       fifo_full_i,
    output logic             write_symbol_o,
    output logic [29:0]      symbol_o,
    output logic             streaming_o,
    output logic [CNT_W-1:0] filler_count_o,
    output logic             misaligned_o
);

    localparam int          SKEW_W        = $clog2(MISALIGN_LIM + 1);
    localparam logic [29:0] FILLER_TRIPLE = {FILLER_CH2, FILLER_CH1, FILLER_CH0};
    localparam logic [7:0]  PRIME_END     = 8'(PRIME_WRITES);
    localparam logic [SKEW_W-1:0] SKEW_END = SKEW_W'(MISALIGN_LIM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_STREAM
    } state_t;

    state_t             state_q, state_d;
    logic [29:0]        hold_q, hold_d;
    logic               hold_v_q, hold_v_d;
    logic [7:0]         prime_cnt_q, prime_cnt_d;
    logic [CNT_W-1:0]   filler_count_q, filler_count_d;
    logic               misaligned_q, misaligned_d;
    logic [SKEW_W-1:0]  skew_cnt_q, skew_cnt_d;

    logic all_free;
    logic all_full;
    logic skewed;
    logic filler_inc;

    assign all_free = ~|fifo_full_i;
    assign all_full = &fifo_full_i;
    assign skewed   = ~all_free & ~all_full;

    assign symbol_o       = hold_v_q ? hold_q : FILLER_TRIPLE;
    assign streaming_o    = (state_q == ST_STREAM);
    assign filler_count_o = filler_count_q;
    assign misaligned_o   = misaligned_q;

    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        hold_v_d       = hold_v_q;
        prime_cnt_d    = prime_cnt_q;
        filler_count_d = filler_count_q;
        misaligned_d   = misaligned_q;
        skew_cnt_d     = skew_cnt_q;
        write_symbol_o = 1'b0;
        sym_ready_o    = 1'b0;
        filler_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                hold_v_d = 1'b0;
                if (enable_i) begin
                    state_d     = ST_PRIME;
                    prime_cnt_d = 8'd0;
                end
            end
            ST_PRIME: begin
                write_symbol_o = all_free;
                if (all_free) begin
                    prime_cnt_d = prime_cnt_q + 8'd1;
                end
                if ((prime_cnt_d == PRIME_END) || all_full) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                write_symbol_o = all_free;
                sym_ready_o    = ~hold_v_q | all_free;
                if (all_free) begin
                    if (hold_v_q) begin
                        hold_v_d = 1'b0;
                    end else begin
                        filler_inc = 1'b1;
                    end
                end
                if (sym_valid_i && sym_ready_o) begin
                    hold_d   = sym_data_i;
                    hold_v_d = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                hold_v_d = 1'b0;
            end
        endcase

        // Losing enable abandons the pipeline, but this cycle's write has already gone out.
        if ((state_q != ST_IDLE) && !enable_i) begin
            state_d  = ST_IDLE;
            hold_v_d = 1'b0;
        end

        if (filler_inc && !(&filler_count_q)) begin
            filler_count_d = filler_count_q + 1'b1;
        end

        if (skewed) begin
            if (skew_cnt_q != SKEW_END) begin
                skew_cnt_d = skew_cnt_q + 1'b1;
            end
        end else begin
            skew_cnt_d = '0;
        end
        if (skew_cnt_d == SKEW_END) begin
            misaligned_d = 1'b1;
        end

        if (clear_stats_i) begin
            filler_count_d = '0;
            misaligned_d   = 1'b0;
            skew_cnt_d     = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q        <= ST_IDLE;
            hold_q         <= '0;
            hold_v_q       <= 1'b0;
            prime_cnt_q    <= 8'd0;
            filler_count_q <= '0;
            misaligned_q   <= 1'b0;
            skew_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            hold_v_q       <= hold_v_d;
            prime_cnt_q    <= prime_cnt_d;
            filler_count_q <= filler_count_d;
            misaligned_q   <= misaligned_d;
            skew_cnt_q     <= skew_cnt_d;
        end
    end

endmodule
